fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Drives the write side of the program counter: produces the next-PC value and the PC write strobe W_PC.
- Consumes the PC's registered output to fetch instructions over a req/ack instruction-memory handshake.
- Presents one buffered instruction, with its PC, to decode under a valid/stall rule.
- Handles reset-vector load, sequential increment, branch redirect and discard of stale memory responses.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded after reset.
- INCR, 4, byte increment per sequential fetch.

Ports:
- CLK  input  1  system clock, all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- pc_cur  input  XLEN  current PC, taken from program_counter out.
- pc_next  output  XLEN  value presented to program_counter in.
- W_PC  output  1  PC write enable; PC loads pc_next on the edge where W_PC=1.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  XLEN  fetch address.
- imem_ack  input  1  response valid, one cycle per request.
- imem_data  input  XLEN  instruction word, valid with imem_ack.
- instr  output  XLEN  buffered instruction to decode.
- instr_pc  output  XLEN  PC of instr.
- instr_valid  output  1  instr/instr_pc hold a valid entry.
- stall  input  1  decode cannot accept; hold instr.
- branch_taken  input  1  redirect request, single-cycle pulse.
- branch_target  input  XLEN  redirect address.

Behaviour:
- Reset (RST=1, asynchronous): state=BOOT; instr=0, instr_pc=0, instr_valid=0, imem_req=0.
- Reset combinational outputs: W_PC=0 and pc_next=RESET_VECTOR while RST=1.
- Reset mid-request: any in-flight response is ignored after RST deasserts.
- States: BOOT, REQ, HOLD, DROP.
- BOOT: W_PC=1, pc_next=RESET_VECTOR for one cycle, then go to REQ. No imem_req in BOOT.
- REQ: imem_req=1 and imem_addr=pc_cur, held stable until imem_ack.
  - On imem_ack with no branch: capture imem_data into instr and pc_cur into instr_pc, set instr_valid=1.
  - Same cycle: W_PC=1 and pc_next=pc_cur+INCR (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0).
  - Next state: HOLD if stall=1 in that cycle, otherwise stay in REQ. Back-to-back fetches give 1 instruction per ack.
- HOLD: imem_req=0, instr/instr_pc/instr_valid frozen, W_PC=0. When stall=0, go to REQ and clear instr_valid on the same edge.
- Buffer consumption rule: instr_valid is cleared on any edge where stall=0 and no new ack is captured.
- W_PC and pc_next are combinational (Mealy) outputs. W_PC is never asserted in a cycle with neither BOOT, ack nor branch.
- Branch (branch_taken=1) has top priority in every state except BOOT, where it is ignored:
  - W_PC=1, pc_next = {branch_target[XLEN-1:2], 2'b00}; instr_valid cleared next edge.
  - A coincident imem_ack is discarded.
  - If in REQ without ack in that cycle, the request is outstanding: go to DROP. Otherwise go to REQ.
- DROP: imem_req=0. Wait for imem_ack, discard imem_data, go to REQ. A branch while in DROP updates the PC and stays in DROP.
- Simultaneous stall and branch: branch wins, HOLD exited.
- Latency: first imem_req is 1 cycle after RST deassert (BOOT). Ack-to-instr_valid is 1 edge.

Decomposition:
- Shared package fetch_pkg holds: state encoding localparams (BOOT=2'd0, REQ=2'd1, HOLD=2'd2, DROP=2'd3), INCR, RESET_VECTOR default.
- One natural sub-module, pc_incrementer: combinational XLEN adder plus branch-target alignment mux producing pc_next. The FSM stays in fetch_sequencer.

Test Plan:
- Reset release, RESET_VECTOR=32'h100: cycle 1 W_PC=1, pc_next=32'h100; cycle 2 imem_req=1, imem_addr=32'h100.
- Ack every cycle, stall=0, data 32'hA,32'hB: instr_pc 32'h100,32'h104 with instr_valid=1. pc_next 32'h104,32'h108 with W_PC=1 on each ack.
- stall=1 held 3 cycles after an ack: instr/instr_pc frozen, imem_req=0, W_PC=0. Release gives imem_req=1 at next PC.
- branch_taken with target 32'h203 while request pending: pc_next=32'h200, W_PC=1, state DROP. Late ack data 32'hDEAD never appears on instr. Next imem_addr=32'h200.
- PC wrap: pc_cur=32'hFFFF_FFFC, ack -> pc_next=32'h0.
- RST pulsed mid-REQ: instr_valid=0 and imem_req=0 immediately, without waiting for CLK. BOOT sequence repeats.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// next-PC source selection and default parameter values.
package fetch_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam int          INCR_DEFAULT         = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] BOOT_ENC = 2'd0;
  localparam logic [1:0] REQ_ENC  = 2'd1;
  localparam logic [1:0] HOLD_ENC = 2'd2;
  localparam logic [1:0] DROP_ENC = 2'd3;

  typedef enum logic [1:0] {
    BOOT = BOOT_ENC,
    REQ  = REQ_ENC,
    HOLD = HOLD_ENC,
    DROP = DROP_ENC
  } state_t;

  typedef enum logic [1:0] {
    SEL_RESET  = 2'd0,
    SEL_INCR   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_HOLD   = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/pc_incrementer.sv
// Next-PC source mux: reset vector, sequential increment (wrapping modulo
// 2^XLEN) or word-aligned branch target.
module pc_incrementer
  import fetch_pkg::*;
#(
  parameter int               XLEN         = XLEN_DEFAULT,
  parameter int               INCR         = INCR_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic [XLEN-1:0] pc_cur,
  input  logic [XLEN-1:0] branch_target,
  input  pc_sel_t         sel,
  output logic [XLEN-1:0] pc_next
);

  logic [XLEN-1:0] pc_incr;
  logic [XLEN-1:0] target_aligned;

  assign pc_incr        = pc_cur + XLEN'(INCR);
  assign target_aligned = branch_target & ~XLEN'(3);

  always_comb begin
    pc_next = pc_cur;
    case (sel)
      SEL_RESET:  pc_next = RESET_VECTOR;
      SEL_INCR:   pc_next = pc_incr;
      SEL_BRANCH: pc_next = target_aligned;
      default:    pc_next = pc_cur;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC write port, issues req/ack instruction
// fetches and buffers one instruction for decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              INCR         = INCR_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            W_PC,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target
);

  state_t  state;
  state_t  state_nxt;
  pc_sel_t pc_sel;
  logic    capture;
  logic    clear_valid;

  assign imem_addr = pc_cur;

  pc_incrementer #(
    .XLEN         (XLEN),
    .INCR         (INCR),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_incrementer (
    .pc_cur        (pc_cur),
    .branch_target (branch_target),
    .sel           (pc_sel),
    .pc_next       (pc_next)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= BOOT;
    else     state <= state_nxt;
  end

  // A branch outranks everything outside BOOT; an ack arriving with it is dropped.
  always_comb begin
    state_nxt   = state;
    pc_sel      = SEL_HOLD;
    W_PC        = 1'b0;
    imem_req    = 1'b0;
    capture     = 1'b0;
    clear_valid = !stall;
    case (state)
      BOOT: begin
        W_PC      = 1'b1;
        pc_sel    = SEL_RESET;
        state_nxt = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          W_PC        = 1'b1;
          pc_sel      = SEL_BRANCH;
          clear_valid = 1'b1;
          state_nxt   = imem_ack ? REQ : DROP;
        end else if (imem_ack) begin
          capture   = 1'b1;
          W_PC      = 1'b1;
          pc_sel    = SEL_INCR;
          state_nxt = stall ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          W_PC        = 1'b1;
          pc_sel      = SEL_BRANCH;
          clear_valid = 1'b1;
          state_nxt   = REQ;
        end else if (!stall) begin
          state_nxt = REQ;
        end
      end
      DROP: begin
        // The outstanding response is still owed; keep waiting unless it lands now.
        if (branch_taken) begin
          W_PC        = 1'b1;
          pc_sel      = SEL_BRANCH;
          clear_valid = 1'b1;
          state_nxt   = imem_ack ? REQ : DROP;
        end else if (imem_ack) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
    if (RST) begin
      W_PC     = 1'b0;
      pc_sel   = SEL_RESET;
      imem_req = 1'b0;
      capture  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr       <= imem_data;
      instr_pc    <= pc_cur;
      instr_valid <= 1'b1;
    end else if (clear_valid) begin
      instr_valid <= 1'b0;
    end
  end

  a_wpc_source: assert property (@(posedge CLK) disable iff (RST)
    W_PC |-> (state == BOOT || imem_ack || branch_taken));

  a_req_addr_stable: assert property (@(posedge CLK) disable iff (RST)
    (imem_req && !imem_ack && !branch_taken) |=> (imem_req && $stable(imem_addr)));

  a_hold_quiet: assert property (@(posedge CLK) disable iff (RST)
    (state == HOLD) |-> (!imem_req && (!W_PC || branch_taken)));

endmodule
